// File: rtl/ballot_unit.sv
// rtl/ballot_unit.sv - armed single-voter ballot front end: debounce, multi-press reject, timeout, one-hot vote
module ballot_unit #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000,
    parameter int CW              = 21
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic [3:0]    btn,
    output logic [3:0]    vote,
    output logic          ready,
    output logic          cast_done,
    output logic          err_multi,
    output logic          timeout,
    output logic [CW-1:0] ballots
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DEBOUNCE,
        S_CAST,
        S_RELEASE
    } state_t;

    state_t        state, state_n;
    logic [3:0]    cap, cap_n;
    logic [DW-1:0] dcnt, dcnt_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          multi_seen;
    logic          err_n, to_n;
    logic          one_hot, multi, expire, open_n;

    assign one_hot = (btn != 4'd0) && ((btn & (btn - 4'd1)) == 4'd0);
    assign multi   = (btn != 4'd0) && !one_hot;
    assign expire  = ((state == S_ARMED) || (state == S_DEBOUNCE)) && (tcnt == T_LAST);
    assign open_n  = (state_n == S_ARMED) || (state_n == S_DEBOUNCE);

    always_comb begin
        state_n = state;
        cap_n   = cap;
        dcnt_n  = dcnt;
        tcnt_n  = tcnt;
        err_n   = 1'b0;
        to_n    = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) begin
                    state_n = S_ARMED;
                    tcnt_n  = '0;
                end
            end
            S_ARMED: begin
                // expiry wins over capture and over the multi-press error
                if (expire) begin
                    state_n = S_IDLE;
                    to_n    = 1'b1;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                    if (one_hot) begin
                        cap_n   = btn;
                        dcnt_n  = '0;
                        state_n = S_DEBOUNCE;
                    end else if (multi && !multi_seen) begin
                        err_n = 1'b1;
                    end
                end
            end
            S_DEBOUNCE: begin
                if (expire) begin
                    state_n = S_IDLE;
                    to_n    = 1'b1;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                    if (btn == cap) begin
                        if (dcnt == D_LAST) state_n = S_CAST;
                        else                dcnt_n  = dcnt + 1'b1;
                    end else begin
                        state_n = S_ARMED;
                    end
                end
            end
            S_CAST:    state_n = S_RELEASE;
            S_RELEASE: if (btn == 4'd0) state_n = S_IDLE;
            default:   state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cap        <= 4'd0;
            dcnt       <= '0;
            tcnt       <= '0;
            multi_seen <= 1'b0;
            vote       <= 4'd0;
            ready      <= 1'b0;
            cast_done  <= 1'b0;
            err_multi  <= 1'b0;
            timeout    <= 1'b0;
            ballots    <= '0;
        end else begin
            state      <= state_n;
            cap        <= cap_n;
            dcnt       <= dcnt_n;
            tcnt       <= tcnt_n;
            // remembers an ongoing multi-press so a held one errors only once
            multi_seen <= (state == S_ARMED) && multi;
            vote       <= (state == S_CAST) ? cap : 4'd0;
            cast_done  <= (state == S_CAST);
            ready      <= open_n;
            err_multi  <= err_n;
            timeout    <= to_n;
            if ((state == S_CAST) && !(&ballots)) ballots <= ballots + 1'b1;
        end
    end

endmodule

// File: tb/tb_ballot_unit.sv
// tb/tb_ballot_unit.sv - vector table, corner sequences and random run against a ballot-level model
module tb_ballot_unit;

    localparam int DB = 4;
    localparam int TO = 20;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          arm = 1'b0;
    logic [3:0]    btn = 4'd0;
    logic [3:0]    vote;
    logic          ready, cast_done, err_multi, timeout;
    logic [CW-1:0] ballots;

    ballot_unit #(.DEBOUNCE_CYCLES(DB), .TIMEOUT_CYCLES(TO), .CW(CW)) dut (
        .clk(clk), .rst(rst), .arm(arm), .btn(btn), .vote(vote), .ready(ready),
        .cast_done(cast_done), .err_multi(err_multi), .timeout(timeout), .ballots(ballots)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int nvotes = 0;

    // ballot-level model: an open ballot has an age, an optional captured button and a run of matches
    bit         m_open, m_pending, m_hold, m_mprev;
    logic [3:0] m_cap;
    int         m_run, m_age, m_ballots;
    logic [3:0] e_vote;
    bit         e_ready, e_cd, e_err, e_to;

    typedef struct {
        logic       r;
        logic       a;
        logic [3:0] b;
        logic [3:0] v;
        logic       rdy;
        logic       cd;
        logic       er;
        logic       t;
        int         bal;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit a, input logic [3:0] b);
        int pc;
        bit nm;
        pc = $countones(b);
        nm = 1'b0;
        e_vote = 4'd0; e_cd = 0; e_err = 0; e_to = 0;
        if (r) begin
            m_open = 0; m_pending = 0; m_hold = 0; m_cap = 4'd0;
            m_run = 0; m_age = 0; m_ballots = 0;
        end else if (m_pending) begin
            e_vote = m_cap; e_cd = 1;
            if (m_ballots < (1 << CW) - 1) m_ballots++;
            m_pending = 0; m_hold = 1;
        end else if (m_hold) begin
            if (b == 4'd0) m_hold = 0;
        end else if (!m_open) begin
            if (a) begin m_open = 1; m_age = 0; m_cap = 4'd0; end
        end else if (m_age == TO - 1) begin
            e_to = 1; m_open = 0;
        end else begin
            m_age++;
            if (m_cap == 4'd0) begin
                if (pc == 1) begin m_cap = b; m_run = 0; end
                else if (pc >= 2) begin e_err = !m_mprev; nm = 1; end
            end else if (b == m_cap) begin
                m_run++;
                if (m_run == DB) begin m_pending = 1; m_open = 0; end
            end else begin
                m_cap = 4'd0;
            end
        end
        m_mprev = nm;
        e_ready = m_open;
    endtask

    task automatic step(input bit r, input bit a, input logic [3:0] b);
        rst = r; arm = a; btn = b;
        @(posedge clk);
        model_edge(r, a, b);
        #1;
        if (vote != 4'd0) nvotes++;
        chk("vote", vote, e_vote);
        chk("ready", ready, e_ready);
        chk("cast_done", cast_done, e_cd);
        chk("err_multi", err_multi, e_err);
        chk("timeout", timeout, e_to);
        chk("ballots", ballots, m_ballots);
    endtask

    task automatic add(input logic r, a, input logic [3:0] b, input logic [3:0] v,
                       input logic rdy, cd, er, t, input int bal, input int n);
        vec_t x;
        x.r = r; x.a = a; x.b = b; x.v = v; x.rdy = rdy; x.cd = cd; x.er = er; x.t = t; x.bal = bal;
        for (int i = 0; i < n; i++) tbl.push_back(x);
    endtask

    task automatic cast_one(input logic [3:0] b);
        step(0, 1, 4'd0);
        for (int i = 0; i < DB + 3; i++) step(0, 0, b);
        step(0, 0, 4'd0);
    endtask

    initial begin
        // nominal vote then multi-press followed by a clean vote
        add(1, 0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 1);
        add(0, 1, 4'h0, 4'h0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 4'h4, 4'h0, 1, 0, 0, 0, 0, 4);
        add(0, 0, 4'h4, 4'h0, 0, 0, 0, 0, 0, 1);
        add(0, 0, 4'h4, 4'h4, 0, 1, 0, 0, 1, 1);
        add(0, 1, 4'h4, 4'h0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 1, 1);
        add(0, 1, 4'h0, 4'h0, 1, 0, 0, 0, 1, 1);
        add(0, 0, 4'h3, 4'h0, 1, 0, 1, 0, 1, 1);
        add(0, 0, 4'h3, 4'h0, 1, 0, 0, 0, 1, 4);
        add(0, 0, 4'h8, 4'h0, 1, 0, 0, 0, 1, 4);
        add(0, 0, 4'h8, 4'h0, 0, 0, 0, 0, 1, 1);
        add(0, 0, 4'h8, 4'h8, 0, 1, 0, 0, 2, 1);
        add(0, 0, 4'h0, 4'h0, 0, 0, 0, 0, 2, 1);
        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].a, tbl[i].b);
            chk($sformatf("tbl%0d_vote", i), vote, tbl[i].v);
            chk($sformatf("tbl%0d_ready", i), ready, tbl[i].rdy);
            chk($sformatf("tbl%0d_cast", i), cast_done, tbl[i].cd);
            chk($sformatf("tbl%0d_err", i), err_multi, tbl[i].er);
            chk($sformatf("tbl%0d_to", i), timeout, tbl[i].t);
            chk($sformatf("tbl%0d_bal", i), ballots, tbl[i].bal);
        end

        // bounce: toggling button never votes, a steady one votes once
        step(1, 0, 4'd0);
        nvotes = 0;
        step(0, 1, 4'd0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 4'h1); step(0, 0, 4'h1);
            step(0, 0, 4'h0); step(0, 0, 4'h0);
        end
        chk("bounce_no_vote", nvotes, 0);
        for (int i = 0; i < DB + 3; i++) step(0, 0, 4'h1);
        step(0, 0, 4'h0);
        chk("bounce_votes", nvotes, 1);
        chk("bounce_ballots", ballots, 1);

        // held button through cast, arm pulses ignored until release
        nvotes = 0;
        step(0, 1, 4'd0);
        for (int i = 0; i < DB + 3; i++) step(0, 0, 4'h2);
        step(0, 1, 4'h2); step(0, 0, 4'h2); step(0, 1, 4'h2);
        for (int i = 0; i < 4; i++) step(0, 0, 4'h2);
        chk("held_one_vote", nvotes, 1);
        chk("held_ready", ready, 0);
        step(0, 0, 4'h0);
        cast_one(4'h2);
        chk("rearm_votes", nvotes, 2);
        chk("rearm_ballots", ballots, 3);

        // timeout after TO cycles with no press, later press ignored
        step(1, 0, 4'd0);
        nvotes = 0;
        step(0, 1, 4'd0);
        for (int i = 0; i < TO - 1; i++) step(0, 0, 4'd0);
        chk("to_not_early", timeout, 0);
        step(0, 0, 4'd0);
        chk("to_pulse", timeout, 1);
        chk("to_ready", ready, 0);
        for (int i = 0; i < DB + 4; i++) step(0, 0, 4'h4);
        chk("to_no_vote", nvotes, 0);
        chk("to_ballots", ballots, 0);

        // reset on the edge that would enter the cast
        step(0, 0, 4'h0);
        step(0, 1, 4'd0);
        for (int i = 0; i < DB; i++) step(0, 0, 4'h1);
        step(1, 0, 4'h1);
        for (int i = 0; i < 4; i++) step(0, 0, 4'h1);
        chk("rst_no_vote", nvotes, 0);
        chk("rst_ballots", ballots, 0);

        // saturation at 2**CW-1
        step(0, 0, 4'h0);
        for (int k = 0; k < 5; k++) cast_one(4'h8);
        chk("sat_votes", nvotes, 5);
        chk("sat_ballots", ballots, 3);

        // random traffic against the model
        step(1, 0, 4'd0);
        for (int n = 0; n < 4000; n++) begin
            logic [3:0] nb;
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 5)      nb = btn;
            else if (sel < 7) nb = 4'd0;
            else if (sel < 9) nb = 4'd1 << $urandom_range(0, 3);
            else              nb = 4'($urandom);
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 5) == 0), nb);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ballot_unit.md
Name: ballot_unit

Overview:
- Voter-facing front end of the four-candidate voting machine.
- An officer arms the unit for exactly one voter. The unit debounces the four candidate buttons and rejects multi-button presses.
- It emits exactly one single-cycle one-hot vote pulse. That pulse drives the up inputs of the per-candidate vote counters.
- It also keeps a running total of ballots cast, used to cross-check the sum of the candidate counts.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive cycles a single button must stay stable after capture before the vote is cast (legal range >= 1).
- TIMEOUT_CYCLES, 1000, cycles an armed ballot may stay open before it is voided (legal range >= DEBOUNCE_CYCLES + 2).
- CW, 21, ballot total counter width; matches the candidate counter width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- arm  input  1  officer authorisation; sampled only in IDLE.
- btn  input  4  candidate buttons, level; bit0=a, bit1=b, bit2=c, bit3=d.
- vote  output  4  one-hot vote pulse, one cycle, to counter up inputs; bit mapping as btn.
- ready  output  1  high while a ballot is open (ARMED or DEBOUNCE).
- cast_done  output  1  one-cycle pulse, coincident with vote.
- err_multi  output  1  one-cycle pulse when more than one button is seen in ARMED.
- timeout  output  1  one-cycle pulse when an open ballot is voided.
- ballots  output  CW  total valid ballots cast.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state = IDLE.
  - vote, ready, cast_done, err_multi and timeout all 0.
  - ballots = 0; debounce and timeout counters cleared.
  - Reset mid-DEBOUNCE or mid-CAST suppresses any pending or current vote pulse. ballots is not incremented.
- All outputs are registered. No combinational path from inputs to outputs.
- IDLE:
  - btn is ignored.
  - arm=1 -> ARMED; the timeout counter loads 0.
- ARMED (ready=1):
  - btn==0: stay.
  - btn exactly one-hot: capture btn into cap, debounce count = 0, go to DEBOUNCE.
  - btn has 2 or more bits set: err_multi pulses next cycle; stay in ARMED; nothing is captured.
  - A held multi-press pulses err_multi once per entry into that condition, not every cycle.
  - arm is ignored while the ballot is open.
- DEBOUNCE (ready=1):
  - btn==cap: increment the debounce count. On the DEBOUNCE_CYCLES-th consecutive match, go to CAST.
  - btn!=cap (release, glitch or extra button): return to ARMED with no error pulse.
- Timeout:
  - The timeout counter runs in both ARMED and DEBOUNCE.
  - When it reaches TIMEOUT_CYCLES-1: timeout pulses, state goes to IDLE, no vote.
  - Timeout has priority over a simultaneous CAST transition or err_multi.
- CAST (one cycle):
  - vote = cap, cast_done = 1.
  - ballots increments by 1 and saturates at all-ones (no wrap).
  - Next state RELEASE unconditionally.
- RELEASE:
  - Stays until btn==0 is sampled, then goes to IDLE.
  - A button held through CAST can never produce a second vote.
  - arm is ignored here.
- Latency: a one-hot btn first sampled in ARMED at edge N, held stable, gives vote high in the cycle after edge N+DEBOUNCE_CYCLES+1.
- Invariant: vote is 0 or one-hot at all times. At most one vote per arm pulse.

Test Plan:
- Nominal vote, DEBOUNCE_CYCLES=4: arm pulse, btn=4'b0100 held 10 cycles -> exactly one cycle with vote=4'b0100 and cast_done=1, 6 edges after btn first sampled; ballots=1; ready low afterward.
- Bounce: arm, btn toggles 4'b0001/0 every 2 cycles, then held steady -> no vote during bouncing; a single vote=4'b0001 after 4 stable matches; ballots=1.
- Multi-press: arm, btn=4'b0011 for 5 cycles -> one err_multi pulse, no vote, ready stays 1. Then btn=4'b1000 held -> vote=4'b1000.
- Held button / re-arm: after a cast, keep btn=4'b0010 held and pulse arm twice -> no further vote until btn goes 0 and arm is reasserted. ballots increments only once per full arm/press/release cycle.
- Timeout, TIMEOUT_CYCLES=20: arm, no button -> timeout pulse 20 cycles after ARMED entry, state IDLE, ballots unchanged. A button press arriving after that is ignored.
- Reset and saturation: rst asserted in the DEBOUNCE cycle just before CAST -> vote stays 0 and ballots=0. With CW=2, cast 5 ballots -> ballots sticks at 3.
